bus_arb: RTL

//  Round-robin arbiter that shares one tristate bus among N requesters.

---
 rtl/bus_arb.sv | 94 +++++++++
 1 files changed

// File: rtl/bus_arb.sv
// Round-robin tristate bus arbiter with a one-cycle turnaround between owners
// and an optional timeslice that limits how long one owner holds the bus.
module bus_arb #(
    parameter int N  = 4,
    parameter int TW = 4
) (
    input  logic                 c,
    input  logic                 r,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lst,
    input  logic [TW-1:0]        slice,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] own,
    output logic                 busy
);
    localparam int W = $clog2(N);

    typedef enum logic [1:0] {IDLE, GNT, TURN} state_t;

    state_t        state;
    logic [W-1:0]  ptr;
    logic [TW-1:0] tmr;
    logic          sl_en;

    logic          found;
    logic [W-1:0]  win;
    logic [N-1:0]  win_oh;
    logic          rel;

    // Scan requesters starting at ptr, wrapping modulo N
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = W'(idx);
            end
        end
        win_oh = N'(1) << win;
    end

    // gnt is onehot(own) while in GNT, so req & ~gnt is "anyone else pending"
    always_comb begin
        rel = !req[own] || lst[own] ||
              (sl_en && (tmr == '0) && ((req & ~gnt) != '0));
    end

    always_ff @(posedge c) begin
        if (r) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            own   <= '0;
            ptr   <= '0;
            tmr   <= '0;
            sl_en <= 1'b0;
        end else begin
            unique case (state)
                IDLE, TURN: begin
                    if (found) begin
                        state <= GNT;
                        gnt   <= win_oh;
                        own   <= win;
                        busy  <= 1'b1;
                        tmr   <= slice - TW'(1);
                        sl_en <= (slice != '0);
                    end else begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                GNT: begin
                    if (rel) begin
                        state <= TURN;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= (own == W'(N - 1)) ? '0 : own + W'(1);
                    end else if (tmr != '0) begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
